// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS datapath blocks.
//   DATA_W   : register / ALU operand width
//   ADDR_W   : register index width
//   NUM_REGS : number of architectural registers
//   REG_ZERO : index of the hardwired-zero register ($zero)
//   REG_RA   : index of the return-address register ($ra)
//   reg_idx_t: register index type
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_bank_rd_port.sv
// One combinational read port of the register file.
// Forces index 0 to zero, optionally forwards the write port's data when the
// write targets the register being read, otherwise returns the stored value.
// Ports:
//   reset_n     in  active-low reset; while low the port reads 0 and never forwards
//   rd_addr     in  register index being read
//   stored_data in  committed value of regs[rd_addr]
//   reg_write   in  write enable of the write port
//   write_reg   in  write index of the write port
//   write_data  in  write data of the write port
//   rd_data     out resulting read data
module reg_bank_rd_port
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic fwd_hit;

  always_comb begin
    fwd_hit = 1'b0;
    rd_data = stored_data;
    // A non-zero rd_addr that matches write_reg implies write_reg is non-zero too.
    if (BYPASS != 0) begin
      fwd_hit = reg_write && (write_reg == rd_addr);
    end
    if (!reset_n || (rd_addr == ZERO_IDX)) begin
      rd_data = '0;
    end else if (fwd_hit) begin
      rd_data = write_data;
    end
  end

endmodule

// File: rtl/reg_bank.sv
// MIPS general-purpose register file feeding the ALU operands.
// Two combinational read ports (optional same-cycle write forwarding), one
// synchronous write port, and a debug read port that shows committed state.
// Register 0 is not stored and always reads 0.
// Ports:
//   clk        in  rising-edge clock
//   reset_n    in  asynchronous active-low reset, clears every register
//   read_reg1  in  read port 1 index (rs)
//   read_reg2  in  read port 2 index (rt)
//   read_data1 out read port 1 data -> ALU input1
//   read_data2 out read port 2 data -> ALU input2 / store data
//   reg_write  in  write enable
//   write_reg  in  write index
//   write_data in  write data
//   dbg_addr   in  debug read index
//   dbg_data   out debug read data (committed value, never forwarded)
module reg_bank
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int REG_COUNT = 2 ** ADDR_W;

  // Every entry is driven by exactly one continuous assignment below.
  logic [DATA_W-1:0] regs [REG_COUNT];

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] q_reg;

        // Async clear keeps every location defined; write_reg==0 never
        // matches here, so writes to $zero fall away naturally.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            q_reg <= '0;
          end else if (reg_write && (write_reg == ADDR_W'(gi))) begin
            q_reg <= write_data;
          end
        end

        assign regs[gi] = q_reg;
      end
    end
  endgenerate

  reg_bank_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd_port1 (
    .reset_n     (reset_n),
    .rd_addr     (read_reg1),
    .stored_data (regs[read_reg1]),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .rd_data     (read_data1)
  );

  reg_bank_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd_port2 (
    .reset_n     (reset_n),
    .rd_addr     (read_reg2),
    .stored_data (regs[read_reg2]),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .rd_data     (read_data2)
  );

  // Storage is already cleared during reset, so no extra gating is needed.
  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: one forwarding instance and one
// non-forwarding instance share all inputs and are checked side by side.
module tb_reg_bank;

  logic        clk;
  logic        reset_n;
  logic [4:0]  read_reg1, read_reg2, write_reg, dbg_addr;
  logic        reg_write;
  logic [31:0] write_data;
  logic [31:0] rd1_b, rd2_b, dbg_b;
  logic [31:0] rd1_n, rd2_n, dbg_n;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  reg_bank #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_b), .read_data2(rd2_b),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_b)
  );

  reg_bank #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_n (
    .clk(clk), .reset_n(reset_n),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_n), .read_data2(rd2_n),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  dbg;
    logic [31:0] e1_b;
    logic [31:0] e2_b;
    logic [31:0] e1_n;
    logic [31:0] e2_n;
    logic [31:0] e_dbg;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] w, input logic [31:0] d,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
    reg_write  = we;
    write_reg  = w;
    write_data = d;
    read_reg1  = r1;
    read_reg2  = r2;
    dbg_addr   = dbg;
  endtask

  // Reference read: 0 for $zero, write data when forwarding applies, else stored.
  function automatic logic [31:0] exp_read(input bit byp, input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (byp && reg_write && (write_reg == r)) return write_data;
    return model[r];
  endfunction

  function automatic void commit();
    if (reg_write && (write_reg != 5'd0)) model[write_reg] = write_data;
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endfunction

  initial begin
    // we, wreg, wdata, r1, r2, dbg, e1_b, e2_b, e1_n, e2_n, e_dbg
    vecs[0] = '{1'b1, 5'd8,  32'hDEAD_BEEF, 5'd8,  5'd0, 5'd8,  32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0, 32'd0};
    vecs[1] = '{1'b0, 5'd0,  32'd0,         5'd8,  5'd8, 5'd8,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0, 5'd0,  32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vecs[3] = '{1'b0, 5'd0,  32'd0,         5'd0,  5'd8, 5'd0,  32'd0, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 32'd0};
    vecs[4] = '{1'b1, 5'd9,  32'd7,         5'd9,  5'd9, 5'd9,  32'd7, 32'd7, 32'd0, 32'd0, 32'd0};
    vecs[5] = '{1'b0, 5'd0,  32'd0,         5'd9,  5'd9, 5'd9,  32'd7, 32'd7, 32'd7, 32'd7, 32'd7};
    vecs[6] = '{1'b1, 5'd31, 32'h1234_5678, 5'd8,  5'd9, 5'd31, 32'hDEAD_BEEF, 32'd7, 32'hDEAD_BEEF, 32'd7, 32'd0};
    vecs[7] = '{1'b0, 5'd0,  32'd0,         5'd31, 5'd0, 5'd31, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'd0, 32'h1234_5678};

    clear_model();
    reset_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 5'd8, 5'd31, 5'd8);
    #1;
    chk("reset_rd1", rd1_b, 32'd0);
    chk("reset_rd2", rd2_b, 32'd0);
    chk("reset_dbg", dbg_n, 32'd0);

    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven directed vectors.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wreg, vecs[i].wdata, vecs[i].r1, vecs[i].r2, vecs[i].dbg);
      #1;
      chk($sformatf("vec%0d_rd1_byp", i), rd1_b, vecs[i].e1_b);
      chk($sformatf("vec%0d_rd2_byp", i), rd2_b, vecs[i].e2_b);
      chk($sformatf("vec%0d_rd1_nobyp", i), rd1_n, vecs[i].e1_n);
      chk($sformatf("vec%0d_rd2_nobyp", i), rd2_n, vecs[i].e2_n);
      chk($sformatf("vec%0d_dbg", i), dbg_b, vecs[i].e_dbg);
      commit();
    end

    // Debug sweep of every register against the model.
    for (int a = 1; a < 32; a++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'(a));
      #1;
      chk($sformatf("sweep_dbg%0d", a), dbg_b, model[a]);
    end

    // Asynchronous reset mid-cycle, with a write pending.
    @(negedge clk);
    drive(1'b1, 5'd5, 32'hAA55_AA55, 5'd5, 5'd8, 5'd9);
    #1;
    chk("prereset_fwd", rd1_b, 32'hAA55_AA55);
    reset_n = 1'b0;
    #1;
    clear_model();
    chk("midreset_rd1_byp", rd1_b, 32'd0);
    chk("midreset_rd2_byp", rd2_b, 32'd0);
    chk("midreset_rd2_nobyp", rd2_n, 32'd0);
    chk("midreset_dbg", dbg_b, 32'd0);
    @(posedge clk);
    #1;
    chk("reset_write_ignored", dut_b.g_reg[5].g_store.q_reg, 32'd0);
    // Release between edges; the next edge performs the pending write.
    @(negedge clk);
    reset_n = 1'b1;
    dbg_addr = 5'd5;
    #1;
    chk("release_dbg_pre", dbg_b, 32'd0);
    @(posedge clk);
    #1;
    commit();
    chk("release_dbg_post", dbg_b, 32'hAA55_AA55);

    // Reset in the same cycle as a write: register stays 0.
    @(negedge clk);
    drive(1'b1, 5'd6, 32'h0000_0055, 5'd0, 5'd0, 5'd6);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset_n = 1'b1;
    reg_write = 1'b0;
    clear_model();
    #1;
    chk("reset_wins_dbg6", dbg_b, 32'd0);
    dbg_addr = 5'd5;
    #1;
    chk("reset_cleared_dbg5", dbg_n, 32'd0);

    // ALU usage: SUB of reg1 - reg2.
    @(negedge clk);
    drive(1'b1, 5'd1, 32'd5, 5'd0, 5'd0, 5'd0);
    commit();
    @(negedge clk);
    drive(1'b1, 5'd2, 32'd3, 5'd0, 5'd0, 5'd0);
    commit();
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 5'd0);
    #1;
    chk("alu_sub_byp", rd1_b - rd2_b, 32'd2);
    chk("alu_sub_nobyp", rd1_n - rd2_n, 32'd2);
    @(negedge clk);
    drive(1'b1, 5'd1, 32'd3, 5'd1, 5'd2, 5'd0);
    #1;
    chk("alu_zero_byp", {31'd0, (rd1_b - rd2_b) == 32'd0}, 32'd1);
    chk("alu_zero_nobyp", {31'd0, (rd1_n - rd2_n) == 32'd0}, 32'd0);
    commit();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic [4:0] w;
      @(negedge clk);
      w = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), w, $urandom(),
            ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31)));
      #1;
      chk($sformatf("rnd%0d_rd1_byp", i), rd1_b, exp_read(1'b1, read_reg1));
      chk($sformatf("rnd%0d_rd2_byp", i), rd2_b, exp_read(1'b1, read_reg2));
      chk($sformatf("rnd%0d_rd1_nobyp", i), rd1_n, exp_read(1'b0, read_reg1));
      chk($sformatf("rnd%0d_rd2_nobyp", i), rd2_n, exp_read(1'b0, read_reg2));
      chk($sformatf("rnd%0d_dbg", i), dbg_b, model[dbg_addr]);
      commit();
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
